// File: rtl/cpu_pkg.sv
// ============================================================================
// Module      : cpu_pkg
// Description : Shared bitmap geometry, index type and loader state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int BM_WIDTH = 1536;
  localparam int WORD_W   = 16;
  localparam int BM_WORDS = BM_WIDTH / WORD_W;
  localparam int BM_REGS  = 3;

  typedef logic [1:0] bm_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_COMMIT = 2'd2
  } bl_state_t;

endpackage

`default_nettype wire

// File: rtl/bm_word_buffer.sv
// ============================================================================
// Module      : bm_word_buffer
// Description : NW x W staging register, one indexed write port, flat read bus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bm_word_buffer #(
  parameter int W     = 16,
  parameter int NW    = 96,
  parameter int IDX_W = $clog2(NW)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [W-1:0]      wdata,
  output logic [NW*W-1:0]   rdata
);

  logic [W-1:0] r_slot [NW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NW; k++) r_slot[k] <= '0;
    end else if (we) begin
      for (int k = 0; k < NW; k++) begin
        if (widx == IDX_W'(k)) r_slot[k] <= wdata;
      end
    end
  end

  // Slot k lands at bits [W*k+W-1 : W*k] of the bitmap payload.
  generate
    for (genvar k = 0; k < NW; k++) begin : g_flat
      assign rdata[k*W +: W] = r_slot[k];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/bitmap_loader.sv
// ============================================================================
// Module      : bitmap_loader
// Description : Fetches NW memory words into a staging buffer, then writes
//               them to one reg_file bitmap register in a single cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bitmap_loader
  import cpu_pkg::*;
#(
  parameter int W  = WORD_W,
  parameter int B  = BM_WIDTH,
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  bm_idx_t       dst_bm,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic [W-1:0]  mem_rdata,
  input  logic          mem_rvalid,
  output logic          wbm,
  output bm_idx_t       wbm_addr,
  output logic [B-1:0]  wbm_data
);

  localparam int NW      = B / W;
  localparam int c_IDX_W = $clog2(NW);
  localparam int c_CNT_W = $clog2(NW + 1);

  bl_state_t            r_state;
  bl_state_t            w_state_nxt;
  logic [c_CNT_W-1:0]   r_count;
  logic [AW-1:0]        r_base;
  bm_idx_t              r_dst;

  logic w_start_ok;
  logic w_start_bad;
  logic w_beat;
  logic w_last;

  assign w_start_ok  = (r_state == ST_IDLE) && start && (dst_bm <  bm_idx_t'(BM_REGS));
  assign w_start_bad = (r_state == ST_IDLE) && start && (dst_bm >= bm_idx_t'(BM_REGS));
  assign w_beat      = (r_state == ST_FETCH) && mem_req && mem_rvalid;
  assign w_last      = w_beat && (r_count == c_CNT_W'(NW - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_start_ok) w_state_nxt = ST_FETCH;
      ST_FETCH:  if (w_last)     w_state_nxt = ST_COMMIT;
      ST_COMMIT: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // All handshake outputs are registered; they are loaded from the same
  // conditions that drive the state transitions above.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= '0;
      r_base   <= '0;
      r_dst    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      wbm      <= 1'b0;
      wbm_addr <= '0;
    end else begin
      done <= 1'b0;
      wbm  <= 1'b0;
      err  <= w_start_bad;
      if (w_start_ok) begin
        r_base   <= base_addr;
        r_dst    <= dst_bm;
        r_count  <= '0;
        busy     <= 1'b1;
        mem_req  <= 1'b1;
        mem_addr <= base_addr;
      end
      if (w_beat) begin
        r_count  <= r_count + c_CNT_W'(1);
        mem_addr <= r_base + AW'(r_count) + AW'(1);
      end
      if (w_last) begin
        mem_req  <= 1'b0;
        wbm      <= 1'b1;
        done     <= 1'b1;
        wbm_addr <= r_dst;
      end
      if (r_state == ST_COMMIT) busy <= 1'b0;
    end
  end

  bm_word_buffer #(
    .W    (W),
    .NW   (NW),
    .IDX_W(c_IDX_W)
  ) u_buf (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (w_beat),
    .widx (r_count[c_IDX_W-1:0]),
    .wdata(mem_rdata),
    .rdata(wbm_data)
  );

endmodule

`default_nettype wire
